// File: rtl/moving_average_win_if.sv
// moving_average_win_if: sample-stream and averaged-output bundle for moving_average_win
interface moving_average_win_if #(
    parameter int DATA_W = 16,
    parameter int LOG2_MAX_N = 5,
    parameter int SEL_W = $clog2(LOG2_MAX_N + 1)
);
    logic                     enable;
    logic                     data_refresh;
    logic signed [DATA_W-1:0] din;
    logic [SEL_W-1:0]         win_sel;
    logic                     output_refresh_mode;
    logic                     clear;
    logic signed [DATA_W-1:0] dout;
    logic                     output_pulse;
    logic                     fill_done;
    modport master (
        output enable, data_refresh, din, win_sel, output_refresh_mode, clear,
        input  dout, output_pulse, fill_done
    );
    modport slave (
        input  enable, data_refresh, din, win_sel, output_refresh_mode, clear,
        output dout, output_pulse, fill_done
    );
endinterface

// File: rtl/moving_average_win.sv
// moving_average_win: boxcar average of signed samples over a runtime power-of-two window
// Define MAVG_ROUND_EN for round-half-up output; default is floor (arithmetic shift).
module moving_average_win #(
    parameter int DATA_W = 16,
    parameter int LOG2_MAX_N = 5,
    parameter int SEL_W = $clog2(LOG2_MAX_N + 1)
) (
    input logic clk,
    input logic rst,
    moving_average_win_if.slave bus
);
    localparam int SW = DATA_W + LOG2_MAX_N;
    localparam int CW = LOG2_MAX_N + 1;
    localparam int PW = LOG2_MAX_N;
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
    state_t state_q, state_d;
    logic signed [SW-1:0] sum_q, sum_d, sum_nx;
    logic [CW-1:0] cnt_q, cnt_d, cnt_nx, win;
    logic [PW-1:0] wp_q, wp_d, dec_q, dec_d, rd_ptr, win_m1;
    logic [SEL_W-1:0] n_q, n_d, sel_c;
    logic signed [DATA_W-1:0] dout_q, dout_d, avg;
    logic pulse_q, pulse_d, fill_q, fill_d, acc, flush, full, we;
    logic signed [DATA_W-1:0] ring_q [2**LOG2_MAX_N];
`ifdef MAVG_ROUND_EN
    localparam logic signed [SW:0] MAXP = (SW+1)'(2**(DATA_W-1) - 1);
    logic signed [SW:0] rnd, rsh;
`endif

    assign sel_c = (bus.win_sel > SEL_W'(LOG2_MAX_N)) ? SEL_W'(LOG2_MAX_N) : bus.win_sel;
    assign acc = bus.enable & bus.data_refresh & ~bus.clear;
    // a window change while filling or running discards history exactly like clear
    assign flush = bus.clear | ((state_q != IDLE) && (sel_c != n_q));

    always_comb begin
        n_d = (state_q == IDLE) ? sel_c : n_q;
        win = CW'(1) << n_d;
        win_m1 = PW'(win - CW'(1));
        rd_ptr = wp_q - PW'(win);
        sum_nx = ((state_q == IDLE) ? '0 : sum_q) + SW'(bus.din)
               - ((state_q == RUN) ? SW'(ring_q[rd_ptr]) : '0);
        cnt_nx = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);
        full = (state_q == RUN) || (cnt_nx == win);
`ifdef MAVG_ROUND_EN
        rnd = {sum_nx[SW-1], sum_nx} + ((n_d == '0) ? '0 : ((SW+1)'(1) << (n_d - SEL_W'(1))));
        rsh = rnd >>> n_d;
        avg = (rsh > MAXP) ? DATA_W'(MAXP) : DATA_W'(rsh);
`else
        avg = DATA_W'(sum_nx >>> n_d);
`endif
        state_d = state_q;
        sum_d = sum_q;
        cnt_d = cnt_q;
        wp_d = wp_q;
        dec_d = dec_q;
        dout_d = dout_q;
        pulse_d = 1'b0;
        fill_d = fill_q;
        we = 1'b0;
        if (flush) begin
            state_d = IDLE;
            sum_d = '0;
            cnt_d = '0;
            dec_d = '0;
            fill_d = 1'b0;
        end else if (acc) begin
            we = 1'b1;
            wp_d = wp_q + PW'(1);
            sum_d = sum_nx;
            cnt_d = (state_q == RUN) ? cnt_q : cnt_nx;
            state_d = full ? RUN : FILL;
            fill_d = full;
            if (full) begin
                dout_d = avg;
                pulse_d = (state_q != RUN) || bus.output_refresh_mode || (dec_q == win_m1);
                dec_d = ((state_q != RUN) || (dec_q == win_m1)) ? '0 : dec_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q <= '0;
            cnt_q <= '0;
            wp_q <= '0;
            dec_q <= '0;
            n_q <= '0;
            dout_q <= '0;
            pulse_q <= 1'b0;
            fill_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            wp_q <= wp_d;
            dec_q <= dec_d;
            n_q <= n_d;
            dout_q <= dout_d;
            pulse_q <= pulse_d;
            fill_q <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst) ring_q[wp_q] <= bus.din;
    end

    assign bus.dout = dout_q;
    assign bus.output_pulse = pulse_q;
    assign bus.fill_done = fill_q;
endmodule

// File: tb/tb_moving_average_win.sv
// tb_moving_average_win: scoreboard bench for moving_average_win (honours MAVG_ROUND_EN)
module tb_moving_average_win;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    moving_average_win_if #(.DATA_W(16), .LOG2_MAX_N(5)) bus();
    moving_average_win #(.DATA_W(16), .LOG2_MAX_N(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0, n_err = 0, pulses = 0;
    int exp_q[$];
    int hist[$];
    int m_n = 2, m_dec = 0, m_dout = 0, cur_w = 2;
    bit m_run = 1'b0;

    task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int avg_of(input int s, input int n);
`ifdef MAVG_ROUND_EN
        int r;
        r = (n == 0) ? s : ((s + (1 << (n - 1))) >>> n);
        return (r > 32767) ? 32767 : r;
`else
        return s >>> n;
`endif
    endfunction

    task automatic accept(input int v);
        int n, s;
        n = 1 << m_n;
        s = 0;
        hist.push_back(v);
        if (hist.size() > n) void'(hist.pop_front());
        foreach (hist[i]) s += hist[i];
        if (!m_run) begin
            if (hist.size() == n) begin
                m_run = 1'b1;
                m_dec = 0;
                m_dout = avg_of(s, m_n);
                exp_q.push_back(m_dout);
            end
        end else begin
            m_dout = avg_of(s, m_n);
            if (bus.output_refresh_mode || m_dec == n - 1) exp_q.push_back(m_dout);
            m_dec = (m_dec == n - 1) ? 0 : m_dec + 1;
        end
    endtask

    task automatic step(input int v, input bit en, input bit clr, input int w);
        int wc;
        wc = (w > 5) ? 5 : w;
        @(negedge clk);
        bus.din = 16'(v);
        bus.data_refresh = 1'b1;
        bus.enable = en;
        bus.clear = clr;
        bus.win_sel = 3'(w);
        @(posedge clk);
        if (clr || (hist.size() > 0 && wc != m_n)) begin
            hist.delete();
            m_run = 1'b0;
            m_n = wc;
        end else begin
            if (hist.size() == 0) m_n = wc;
            if (en) accept(v);
        end
        #1;
        bus.data_refresh = 1'b0;
        bus.clear = 1'b0;
        bus.enable = 1'b1;
    endtask

    task automatic send(input int v);
        step(v, 1'b1, 1'b0, cur_w);
    endtask

    task automatic set_win(input int w);
        cur_w = w;
        step(0, 1'b0, 1'b0, w);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("fill_done", bus.fill_done, m_run);
            if (bus.output_pulse) begin
                pulses++;
                if (exp_q.size() == 0) chk("spurious_pulse", bus.output_pulse, 0);
                else chk("dout", bus.dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        int t1[5] = '{4, 8, 12, 16, 20};
        bus.enable = 1'b1;
        bus.data_refresh = 1'b0;
        bus.din = '0;
        bus.clear = 1'b0;
        bus.win_sel = 3'd2;
        bus.output_refresh_mode = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", bus.dout, 0);
        chk("rst_pulse", bus.output_pulse, 0);
        chk("rst_fill", bus.fill_done, 0);
        rst = 1'b0;
        foreach (t1[i]) send(t1[i]);
        set_win(1);
        send(-3);
        send(-4);
        set_win(2);
        bus.output_refresh_mode = 1'b0;
        pulses = 0;
        repeat (12) send(100);
        repeat (2) @(posedge clk);
        chk("decim_pulses", pulses, 3);
        bus.output_refresh_mode = 1'b1;
        step(55, 1'b1, 1'b1, 2);
        for (int i = 1; i <= 6; i++) send(i * 10);
        cur_w = 3;
        step(999, 1'b1, 1'b0, 3);
        pulses = 0;
        for (int i = 0; i < 8; i++) send(i * 7 - 20);
        repeat (2) @(posedge clk);
        chk("win_change_pulses", pulses, 1);
        set_win(7);
        repeat (32) send(32767);
        repeat (32) send(-32768);
        set_win(0);
        bus.output_refresh_mode = 1'b0;
        send(5);
        send(-9);
        send(3);
        bus.output_refresh_mode = 1'b1;
        set_win(2);
        send(1);
        send(2);
        step(77, 1'b1, 1'b1, 2);
        chk("clear_hold", bus.dout, m_dout);
        step(50, 1'b0, 1'b0, 2);
        send(4);
        send(4);
        send(8);
        send(8);
        repeat (2) @(posedge clk);
        chk("pending", exp_q.size(), 0);
        #1 rst = 1'b1;
        hist.delete();
        m_run = 1'b0;
        @(posedge clk);
        #1;
        chk("rst2_dout", bus.dout, 0);
        chk("rst2_pulse", bus.output_pulse, 0);
        chk("rst2_fill", bus.fill_done, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
